sdram_arbit: RTL and testbench

SDRAM_ARBIT -- requirements
Module: sdram_arbit

---
 rtl/sdram_arbit.sv | 169 ++++++++++++++++
 tb/tb_sdram_arbit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: fixed-priority grant of refresh > write > read, muxing the owning stage onto the pins.
// Optional watchdog on stuck operations is enabled by defining SDRAM_ARBIT_WDOG_EN.
module sdram_arbit (
    input  logic        sclk,
    input  logic        s_rst_n,
    input  logic        flag_init_end,
    input  logic [3:0]  init_cmd,
    input  logic [12:0] init_addr,
    input  logic        ref_req,
    output logic        ref_en,
    input  logic        flag_ref_end,
    input  logic [3:0]  aref_cmd,
    input  logic [12:0] aref_addr,
    input  logic        wr_req,
    output logic        wr_en,
    input  logic        flag_wr_end,
    input  logic [3:0]  wr_cmd,
    input  logic [12:0] wr_addr,
    input  logic        rd_req,
    output logic        rd_en,
    input  logic        flag_rd_end,
    input  logic [3:0]  rd_cmd,
    input  logic [12:0] rd_addr,
    output logic [3:0]  sdram_cmd,
    output logic [12:0] sdram_addr,
    output logic        err_timeout
);

    localparam logic [3:0] CMD_NOP = 4'b0111;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_ARBIT = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } state_t;

    state_t state_q, state_d;
    logic   ref_en_q, ref_en_d;
    logic   wr_en_q,  wr_en_d;
    logic   rd_en_q,  rd_en_d;
    logic   in_op;
    logic   op_done;

    assign in_op   = (state_q == ST_AREF) || (state_q == ST_WRITE) || (state_q == ST_READ);
    // An end flag only counts when it belongs to the operation currently owning the bus.
    assign op_done = ((state_q == ST_AREF)  && flag_ref_end) ||
                     ((state_q == ST_WRITE) && flag_wr_end)  ||
                     ((state_q == ST_READ)  && flag_rd_end);

`ifdef SDRAM_ARBIT_WDOG_EN
    logic [7:0] wdog_q, wdog_d;
    logic       err_q, err_d;
    logic       wdog_fire;

    assign wdog_fire = in_op && !op_done && (wdog_q == 8'hFF);
`endif

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q  <= ST_INIT;
            ref_en_q <= 1'b0;
            wr_en_q  <= 1'b0;
            rd_en_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ref_en_q <= ref_en_d;
            wr_en_q  <= wr_en_d;
            rd_en_q  <= rd_en_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ref_en_d = 1'b0;
        wr_en_d  = 1'b0;
        rd_en_d  = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (flag_init_end) begin
                    state_d = ST_ARBIT;
                end
            end
            ST_ARBIT: begin
                if (ref_req) begin
                    state_d  = ST_AREF;
                    ref_en_d = 1'b1;
                end else if (wr_req) begin
                    state_d = ST_WRITE;
                    wr_en_d = 1'b1;
                end else if (rd_req) begin
                    state_d = ST_READ;
                    rd_en_d = 1'b1;
                end
            end
            ST_AREF, ST_WRITE, ST_READ: begin
                if (op_done) begin
                    state_d = ST_ARBIT;
                end
`ifdef SDRAM_ARBIT_WDOG_EN
                else if (wdog_fire) begin
                    state_d = ST_ARBIT;
                end
`endif
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

`ifdef SDRAM_ARBIT_WDOG_EN
    // Counts cycles spent in the current operation; leaving it for any reason restarts from zero.
    always_comb begin
        wdog_d = 8'd0;
        err_d  = wdog_fire;
        if (in_op && (state_d == state_q)) begin
            wdog_d = wdog_q + 8'd1;
        end
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            wdog_q <= 8'd0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end

    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

    assign ref_en = ref_en_q;
    assign wr_en  = wr_en_q;
    assign rd_en  = rd_en_q;

    always_comb begin
        sdram_cmd  = CMD_NOP;
        sdram_addr = 13'd0;
        case (state_q)
            ST_INIT: begin
                sdram_cmd  = init_cmd;
                sdram_addr = init_addr;
            end
            ST_AREF: begin
                sdram_cmd  = aref_cmd;
                sdram_addr = aref_addr;
            end
            ST_WRITE: begin
                sdram_cmd  = wr_cmd;
                sdram_addr = wr_addr;
            end
            ST_READ: begin
                sdram_cmd  = rd_cmd;
                sdram_addr = rd_addr;
            end
            default: begin
                sdram_cmd  = CMD_NOP;
                sdram_addr = 13'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_sdram_arbit.sv
// Bench for sdram_arbit: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a bus-ownership model. Honors SDRAM_ARBIT_WDOG_EN like the design.
module tb_sdram_arbit;

    logic        sclk = 1'b0;
    logic        s_rst_n = 1'b0;
    logic        flag_init_end = 1'b0;
    logic [3:0]  init_cmd, aref_cmd, wr_cmd, rd_cmd, sdram_cmd;
    logic [12:0] init_addr, aref_addr, wr_addr, rd_addr, sdram_addr;
    logic        ref_req = 1'b0, wr_req = 1'b0, rd_req = 1'b0;
    logic        flag_ref_end = 1'b0, flag_wr_end = 1'b0, flag_rd_end = 1'b0;
    logic        ref_en, wr_en, rd_en, err_timeout;

    sdram_arbit dut (
        .sclk(sclk), .s_rst_n(s_rst_n), .flag_init_end(flag_init_end),
        .init_cmd(init_cmd), .init_addr(init_addr),
        .ref_req(ref_req), .ref_en(ref_en), .flag_ref_end(flag_ref_end),
        .aref_cmd(aref_cmd), .aref_addr(aref_addr),
        .wr_req(wr_req), .wr_en(wr_en), .flag_wr_end(flag_wr_end),
        .wr_cmd(wr_cmd), .wr_addr(wr_addr),
        .rd_req(rd_req), .rd_en(rd_en), .flag_rd_end(flag_rd_end),
        .rd_cmd(rd_cmd), .rd_addr(rd_addr),
        .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr),
        .err_timeout(err_timeout)
    );

    always #5 sclk = ~sclk;

`ifdef SDRAM_ARBIT_WDOG_EN
    localparam bit WDOG = 1'b1;
`else
    localparam bit WDOG = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: who owns the bus (0 init, 1 idle, 2 refresh, 3 write, 4 read),
    // which grant pulse is due, and how many cycles the current owner has held the bus.
    int m_owner = 0;
    int m_pulse = 0;
    bit m_err = 1'b0;
    int m_held = 0;
    bit m_valid = 1'b0;

    always @(posedge sclk or negedge s_rst_n) begin
        int own, pul, held;
        bit er, done;
        if (!s_rst_n) begin
            m_owner <= 0; m_pulse <= 0; m_err <= 1'b0; m_held <= 0; m_valid <= 1'b1;
        end else begin
            own = m_owner; held = m_held; pul = 0; er = 1'b0;
            if (own == 0) begin
                if (flag_init_end) own = 1;
            end else if (own == 1) begin
                if (ref_req)     begin own = 2; pul = 2; held = 1; end
                else if (wr_req) begin own = 3; pul = 3; held = 1; end
                else if (rd_req) begin own = 4; pul = 4; held = 1; end
            end else begin
                done = (own == 2 && flag_ref_end) || (own == 3 && flag_wr_end) ||
                       (own == 4 && flag_rd_end);
                if (done) own = 1;
                else if (WDOG && held == 256) begin own = 1; er = 1'b1; end
                else held = held + 1;
            end
            m_owner <= own; m_pulse <= pul; m_err <= er; m_held <= held;
        end
    end

    always @(negedge sclk) begin
        logic [3:0]  ecmd;
        logic [12:0] eaddr;
        if (m_valid) begin
            case (m_owner)
                0:       begin ecmd = init_cmd; eaddr = init_addr; end
                2:       begin ecmd = aref_cmd; eaddr = aref_addr; end
                3:       begin ecmd = wr_cmd;   eaddr = wr_addr;   end
                4:       begin ecmd = rd_cmd;   eaddr = rd_addr;   end
                default: begin ecmd = 4'b0111;  eaddr = 13'd0;     end
            endcase
            chk("m_ref_en", ref_en, m_pulse == 2);
            chk("m_wr_en", wr_en, m_pulse == 3);
            chk("m_rd_en", rd_en, m_pulse == 4);
            chk("m_err_timeout", err_timeout, m_err);
            chk("m_sdram_cmd", sdram_cmd, ecmd);
            chk("m_sdram_addr", sdram_addr, eaddr);
        end
    end

    initial begin
        logic [3:0] exp_cmd;
        logic       exp_err;
        int         init_hold;
        init_cmd = 4'h1; init_addr = 13'h0AAA;
        aref_cmd = 4'h2; aref_addr = 13'h0BBB;
        wr_cmd   = 4'h4; wr_addr   = 13'h0123;
        rd_cmd   = 4'h5; rd_addr   = 13'h0400;

        // Reset and INIT
        repeat (3) @(negedge sclk);
        chk("rst_cmd", sdram_cmd, 4'h1);
        chk("rst_addr", sdram_addr, 13'h0AAA);
        chk("rst_outs", {ref_en, wr_en, rd_en, err_timeout}, 4'b0000);
        #1 s_rst_n = 1'b1; ref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
        repeat (5) begin
            @(negedge sclk);
            chk("init_ignore_req", {ref_en, wr_en, rd_en}, 3'b000);
            chk("init_cmd_hold", sdram_cmd, 4'h1);
        end
        #1 ref_req = 1'b0; wr_req = 1'b0; rd_req = 1'b0; flag_init_end = 1'b1;
        @(negedge sclk);
        chk("arbit_nop_cmd", sdram_cmd, 4'b0111);
        chk("arbit_nop_addr", sdram_addr, 13'd0);

        // Simultaneous requests: refresh wins, then write
        #1 ref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
        @(negedge sclk);
        chk("prio_grants", {ref_en, wr_en, rd_en}, 3'b100);
        chk("prio_aref_cmd", sdram_cmd, 4'h2);
        chk("prio_aref_addr", sdram_addr, 13'h0BBB);
        #1 ref_req = 1'b0;
        repeat (3) begin
            @(negedge sclk);
            chk("aref_one_pulse", {ref_en, wr_en, rd_en}, 3'b000);
            chk("aref_cmd_hold", sdram_cmd, 4'h2);
        end
        #1 flag_ref_end = 1'b1;
        @(negedge sclk);
        chk("post_ref_arbit", sdram_cmd, 4'b0111);
        chk("post_ref_nogrant", {ref_en, wr_en, rd_en}, 3'b000);
        #1 flag_ref_end = 1'b0;
        @(negedge sclk);
        chk("wr_after_ref", {ref_en, wr_en, rd_en}, 3'b010);
        chk("wr_cmd", sdram_cmd, 4'h4);
        chk("wr_addr", sdram_addr, 13'h0123);

        // No preemption during WRITE
        #1 wr_req = 1'b0; rd_req = 1'b0; ref_req = 1'b1;
        repeat (20) begin
            @(negedge sclk);
            chk("no_preempt", {ref_en, wr_en, rd_en}, 3'b000);
            chk("no_preempt_cmd", sdram_cmd, 4'h4);
        end
        #1 flag_wr_end = 1'b1;
        @(negedge sclk);
        chk("post_wr_arbit", sdram_cmd, 4'b0111);
        chk("post_wr_noref", ref_en, 1'b0);
        #1 flag_wr_end = 1'b0;
        @(negedge sclk);
        chk("ref_after_wr", {ref_en, wr_en, rd_en}, 3'b100);
        #1 ref_req = 1'b0; flag_ref_end = 1'b1;
        @(negedge sclk);
        chk("ref_end_arbit", sdram_cmd, 4'b0111);

        // Read alone
        #1 flag_ref_end = 1'b0; rd_req = 1'b1;
        @(negedge sclk);
        chk("rd_grant", {ref_en, wr_en, rd_en}, 3'b001);
        chk("rd_addr", sdram_addr, 13'h0400);
        chk("rd_cmd", sdram_cmd, 4'h5);
        #1 rd_req = 1'b0;
        @(negedge sclk);
        chk("rd_one_pulse", rd_en, 1'b0);
        #1 flag_rd_end = 1'b1;
        @(negedge sclk);
        chk("rd_end_nop", sdram_cmd, 4'b0111);
        chk("rd_end_addr", sdram_addr, 13'd0);

        // Reset mid-WRITE
        #1 flag_rd_end = 1'b0; wr_req = 1'b1;
        @(negedge sclk);
        chk("wr_grant2", wr_en, 1'b1);
        #1 s_rst_n = 1'b0; flag_init_end = 1'b0;
        #1;
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_to_init", sdram_cmd, 4'h1);
        @(negedge sclk);
        #1 s_rst_n = 1'b1; ref_req = 1'b1;
        repeat (4) begin
            @(negedge sclk);
            chk("reinit_ignore", {ref_en, wr_en, rd_en}, 3'b000);
            chk("reinit_cmd", sdram_cmd, 4'h1);
        end
        #1 flag_init_end = 1'b1;
        @(negedge sclk);
        chk("reinit_arbit", sdram_cmd, 4'b0111);
        @(negedge sclk);
        chk("reinit_ref", {ref_en, wr_en, rd_en}, 3'b100);
        #1 ref_req = 1'b0; wr_req = 1'b0; flag_ref_end = 1'b1;
        @(negedge sclk);
        #1 flag_ref_end = 1'b0; rd_req = 1'b1;

        // Stuck READ: watchdog fires after 256 cycles when enabled
        @(negedge sclk);
        chk("wdog_rd_grant", rd_en, 1'b1);
        #1 rd_req = 1'b0;
        for (int k = 1; k <= 260; k++) begin
            @(negedge sclk);
            exp_err = WDOG && (k == 256);
            exp_cmd = (WDOG && k >= 256) ? 4'b0111 : 4'h5;
            chk("wdog_err", err_timeout, exp_err);
            chk("wdog_cmd", sdram_cmd, exp_cmd);
        end
        #1 flag_rd_end = 1'b1;
        @(negedge sclk);
        #1 flag_rd_end = 1'b0;

        // Randomized traffic, checked by the model every cycle
        init_hold = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge sclk);
            #1;
            ref_req = ($urandom_range(0, 9) < 2);
            wr_req  = ($urandom_range(0, 9) < 3);
            rd_req  = ($urandom_range(0, 9) < 3);
            flag_ref_end = ($urandom_range(0, 9) == 0);
            flag_wr_end  = ($urandom_range(0, 9) == 0);
            flag_rd_end  = ($urandom_range(0, 9) == 0);
            init_cmd = 4'($urandom); init_addr = 13'($urandom);
            aref_cmd = 4'($urandom); aref_addr = 13'($urandom);
            wr_cmd   = 4'($urandom); wr_addr   = 13'($urandom);
            rd_cmd   = 4'($urandom); rd_addr   = 13'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                s_rst_n = 1'b0;
                init_hold = $urandom_range(1, 6);
            end else begin
                s_rst_n = 1'b1;
            end
            flag_init_end = (init_hold == 0);
            if (init_hold > 0 && s_rst_n) init_hold--;
        end
        #1 s_rst_n = 1'b1;
        @(negedge sclk);
        @(negedge sclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
